// File: rtl/logic_unit_pipe.sv
// Two-stage AND/OR/XOR/NOT unit with invert, accumulator chaining, flags and illegal-opcode detection.
// Latency 2 cycles, 1 beat/cycle; valid/ready on both sides, stages hold under out_ready low.
module logic_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int OPS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPS-1:0]   opCode,
    input  logic             invert,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             op_err
);

    typedef struct packed {
        logic [OPS-1:0]   opCode;
        logic             invert;
        logic             accEn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1Beat_t;

    s1Beat_t          s1Dat;
    logic             s1Vld;
    logic             s2Vld;
    logic [WIDTH-1:0] acc;

    logic             s2Adv;
    logic             s1Adv;
    logic             inXfer;
    logic             legal;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] rawRes;
    logic [WIDTH-1:0] nextRes;

    assign s2Adv     = s2Vld && out_ready;
    assign s1Adv     = s1Vld && (!s2Vld || s2Adv);
    assign in_ready  = !s1Vld || s1Adv;
    assign inXfer    = in_valid && in_ready;
    assign out_valid = s2Vld;

    // acc already holds the previous beat's result, since that beat left S1 a cycle earlier
    assign legal = $onehot(s1Dat.opCode);
    assign opA   = s1Dat.accEn ? acc : s1Dat.a;

    always_comb begin
        rawRes = '0;
        if (s1Dat.opCode[0])      rawRes = opA & s1Dat.b;
        else if (s1Dat.opCode[1]) rawRes = opA | s1Dat.b;
        else if (s1Dat.opCode[2]) rawRes = opA ^ s1Dat.b;
        else if (s1Dat.opCode[3]) rawRes = ~opA;
        if (s1Dat.invert) rawRes = ~rawRes;
        nextRes = legal ? rawRes : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Vld <= 1'b0;
            s1Dat <= '0;
        end else begin
            if (inXfer) begin
                s1Vld        <= 1'b1;
                s1Dat.opCode <= opCode;
                s1Dat.invert <= invert;
                s1Dat.accEn  <= acc_en;
                s1Dat.a      <= A;
                s1Dat.b      <= B;
            end else if (s1Adv) begin
                s1Vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Vld  <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            parity <= 1'b0;
            op_err <= 1'b0;
        end else begin
            if (s1Adv) begin
                s2Vld  <= 1'b1;
                result <= nextRes;
                zero   <= (nextRes == '0);
                parity <= ^nextRes;
                op_err <= !legal;
            end else if (s2Adv) begin
                s2Vld <= 1'b0;
            end
        end
    end

    // a legal result entering S2 overrides a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (s1Adv && legal) begin
            acc <= nextRes;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

endmodule
